// File: rtl/regfile_access_ctrl_if.sv
// Bundle of every handshake and bus signal around the regfile access controller.
// master: the controller itself (takes requests upstream, initiates regfile reads/writes).
// slave:  the environment around it (decode/execute, writeback and the regfile).
interface regfile_access_ctrl_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_rs1;
  logic [AW-1:0]   req_rs2;
  logic            req_use_rs1;
  logic            req_use_rs2;

  logic            op_valid;
  logic            op_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  logic [AW-1:0]   rd_addr_a;
  logic [AW-1:0]   rd_addr_b;
  logic            rd_addr_a_valid;
  logic            rd_addr_b_valid;
  logic [XLEN-1:0] rd_data_a;
  logic [XLEN-1:0] rd_data_b;
  logic            rd_data_a_ack;
  logic            rd_data_b_ack;

  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            wr_data_valid;
  logic            wr_ack;

  modport master (
    input  req_valid, req_rs1, req_rs2, req_use_rs1, req_use_rs2,
    output req_ready,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    output rd_addr_a, rd_addr_b, rd_addr_a_valid, rd_addr_b_valid,
    input  rd_data_a, rd_data_b, rd_data_a_ack, rd_data_b_ack,
    output wr_addr, wr_data, wr_data_valid,
    input  wr_ack
  );

  modport slave (
    output req_valid, req_rs1, req_rs2, req_use_rs1, req_use_rs2,
    input  req_ready,
    input  op_valid, op_a, op_b,
    output op_ready,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    input  rd_addr_a, rd_addr_b, rd_addr_a_valid, rd_addr_b_valid,
    output rd_data_a, rd_data_b, rd_data_a_ack, rd_data_b_ack,
    input  wr_addr, wr_data, wr_data_valid,
    output wr_ack
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: initiator side of the regfile valid/ack protocol.
// Read side fetches rs1/rs2 operands, write side performs writebacks (x0 discarded),
// and reads that touch a register with a write in flight are held off (RAW).
// Optional feature: define REGFILE_CTRL_TIMEOUT_EN to add a sticky ack watchdog.
module regfile_access_ctrl #(
  parameter int XLEN           = 32,
  parameter int AW             = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_access_ctrl_if.master bus,
  output logic                  err_timeout_o
);

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_DRAIN} wr_state_e;

  rd_state_e       r_state_q;
  wr_state_e       w_state_q;

  logic [AW-1:0]   rs1_q, rs2_q;
  logic            need_a_q, need_b_q;
  logic            got_a_q, got_b_q;
  logic            rd_valid_a_q, rd_valid_b_q;
  logic            op_valid_q;
  logic [XLEN-1:0] op_a_q, op_b_q;

  logic [AW-1:0]   wr_addr_q;
  logic [XLEN-1:0] wr_data_q;
  logic            wr_valid_q;

  logic need_a_now, need_b_now, wb_fire, wr_busy, hazard, req_fire;
  logic cap_a, cap_b, all_done, drain_done;
  logic r_tmo, w_tmo;

  // A source only costs a regfile access when it is used and is not x0.
  assign need_a_now = bus.req_use_rs1 && (bus.req_rs1 != '0);
  assign need_b_now = bus.req_use_rs2 && (bus.req_rs2 != '0);
  assign wb_fire    = bus.wb_valid && (w_state_q == W_IDLE);
  assign wr_busy    = (w_state_q != W_IDLE);

  // RAW: a needed source matches the write being performed or the one accepted this cycle.
  assign hazard =
    (need_a_now && ((wr_busy && bus.req_rs1 == wr_addr_q) || (wb_fire && bus.wb_rd == bus.req_rs1))) ||
    (need_b_now && ((wr_busy && bus.req_rs2 == wr_addr_q) || (wb_fire && bus.wb_rd == bus.req_rs2)));

  assign bus.req_ready = (r_state_q == R_IDLE) && !op_valid_q && !hazard;
  assign req_fire      = bus.req_valid && bus.req_ready;

  // An operand is captured on the cycle its ack arrives while its valid is still up.
  assign cap_a      = (r_state_q == R_ISSUE) && rd_valid_a_q && bus.rd_data_a_ack;
  assign cap_b      = (r_state_q == R_ISSUE) && rd_valid_b_q && bus.rd_data_b_ack;
  assign all_done   = (!need_a_q || got_a_q || cap_a) && (!need_b_q || got_b_q || cap_b);
  assign drain_done = !bus.rd_data_a_ack && !bus.rd_data_b_ack;

  assign bus.op_valid        = op_valid_q;
  assign bus.op_a            = op_a_q;
  assign bus.op_b            = op_b_q;
  assign bus.rd_addr_a       = rs1_q;
  assign bus.rd_addr_b       = rs2_q;
  assign bus.rd_addr_a_valid = rd_valid_a_q;
  assign bus.rd_addr_b_valid = rd_valid_b_q;
  assign bus.wb_ready        = (w_state_q == W_IDLE);
  assign bus.wr_addr         = wr_addr_q;
  assign bus.wr_data         = wr_data_q;
  assign bus.wr_data_valid   = wr_valid_q;

  // Read FSM: accept a request, issue the needed reads, collect operands, then wait for acks to clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q    <= R_IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      need_a_q     <= 1'b0;
      need_b_q     <= 1'b0;
      got_a_q      <= 1'b0;
      got_b_q      <= 1'b0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      op_valid_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      if (op_valid_q && bus.op_ready) begin
        op_valid_q <= 1'b0;
      end
      case (r_state_q)
        R_IDLE: begin
          if (req_fire) begin
            rs1_q    <= bus.req_rs1;
            rs2_q    <= bus.req_rs2;
            need_a_q <= need_a_now;
            need_b_q <= need_b_now;
            got_a_q  <= 1'b0;
            got_b_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            if (!need_a_now && !need_b_now) begin
              op_valid_q <= 1'b1;
            end else begin
              rd_valid_a_q <= need_a_now;
              rd_valid_b_q <= need_b_now;
              r_state_q    <= R_ISSUE;
            end
          end
        end
        R_ISSUE: begin
          if (cap_a) begin
            op_a_q       <= bus.rd_data_a;
            got_a_q      <= 1'b1;
            rd_valid_a_q <= 1'b0;
          end
          if (cap_b) begin
            op_b_q       <= bus.rd_data_b;
            got_b_q      <= 1'b1;
            rd_valid_b_q <= 1'b0;
          end
          if (all_done) begin
            op_valid_q <= 1'b1;
            r_state_q  <= R_DRAIN;
          end else if (r_tmo) begin
            op_valid_q   <= 1'b1;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            r_state_q    <= R_IDLE;
          end
        end
        R_DRAIN: begin
          if (drain_done || r_tmo) begin
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Write FSM: latch one writeback, hold the write request until acked, then wait for the ack to clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (wb_fire && bus.wb_rd != '0) begin
            wr_addr_q  <= bus.wb_rd;
            wr_data_q  <= bus.wb_data;
            wr_valid_q <= 1'b1;
            w_state_q  <= W_REQ;
          end
        end
        W_REQ: begin
          if (bus.wr_ack) begin
            wr_valid_q <= 1'b0;
            w_state_q  <= W_DRAIN;
          end else if (w_tmo) begin
            wr_valid_q <= 1'b0;
            w_state_q  <= W_IDLE;
          end
        end
        W_DRAIN: begin
          if (!bus.wr_ack || w_tmo) begin
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

`ifdef REGFILE_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt_q, r_cnt_d, w_cnt_q, w_cnt_d;
  logic          r_leave, w_leave, err_q;

  assign r_leave = ((r_state_q == R_ISSUE) && all_done) || ((r_state_q == R_DRAIN) && drain_done);
  assign w_leave = ((w_state_q == W_REQ) && bus.wr_ack) || ((w_state_q == W_DRAIN) && !bus.wr_ack);
  assign r_tmo   = (r_state_q != R_IDLE) && (r_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign w_tmo   = (w_state_q != W_IDLE) && (w_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog counters count cycles spent in the current waiting state and restart on every state change.
  always_comb begin
    r_cnt_d = r_cnt_q + 1'b1;
    w_cnt_d = w_cnt_q + 1'b1;
    if ((r_state_q == R_IDLE) || r_leave || r_tmo) r_cnt_d = '0;
    if ((w_state_q == W_IDLE) || w_leave || w_tmo) w_cnt_d = '0;
  end

  // Counter registers plus the sticky error flag, which only reset clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_q <= '0;
      w_cnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      r_cnt_q <= r_cnt_d;
      w_cnt_q <= w_cnt_d;
      if (r_tmo || w_tmo) err_q <= 1'b1;
    end
  end

  assign err_timeout_o = err_q;
`else
  // Without the watchdog the FSMs wait on acks forever and the error output is tied off;
  // the AND with the parameter test is always 0 and just keeps the parameter referenced.
  assign r_tmo         = 1'b0;
  assign w_tmo         = 1'b0;
  assign err_timeout_o = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a behavioural regfile that
// answers with registered acks. Expected operands are queued at issue time and
// checked by an independent monitor when the operand handshake completes.
module tb_regfile_access_ctrl;

  logic clk;
  logic reset;
  logic errTimeout;
  logic blockAckA;

  int checks = 0;
  int errors = 0;
  int riseA = 0, riseB = 0, riseWr = 0, riseWrAck = 0;
  logic prevVa = 1'b0, prevVb = 1'b0, prevWr = 1'b0, prevWrAck = 1'b0;

  logic [63:0] expQ[$];
  logic [31:0] regs[32];

  regfile_access_ctrl_if #(.XLEN(32), .AW(5)) rfBus ();

  regfile_access_ctrl #(.XLEN(32), .AW(5), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (rfBus),
    .err_timeout_o(errTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural regfile: registered acks, write committed on the edge the ack rises.
  always @(posedge clk) begin
    if (reset) begin
      rfBus.rd_data_a_ack <= 1'b0;
      rfBus.rd_data_b_ack <= 1'b0;
      rfBus.wr_ack        <= 1'b0;
      rfBus.rd_data_a     <= '0;
      rfBus.rd_data_b     <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + i;
    end else begin
      rfBus.rd_data_a_ack <= rfBus.rd_addr_a_valid && !blockAckA;
      rfBus.rd_data_b_ack <= rfBus.rd_addr_b_valid;
      if (rfBus.rd_addr_a_valid) rfBus.rd_data_a <= regs[rfBus.rd_addr_a];
      if (rfBus.rd_addr_b_valid) rfBus.rd_data_b <= regs[rfBus.rd_addr_b];
      rfBus.wr_ack <= rfBus.wr_data_valid;
      if (rfBus.wr_data_valid && !rfBus.wr_ack) regs[rfBus.wr_addr] <= rfBus.wr_data;
    end
  end

  // Count rising edges of each request line and of the write ack.
  always @(negedge clk) begin
    if (rfBus.rd_addr_a_valid && !prevVa) riseA++;
    if (rfBus.rd_addr_b_valid && !prevVb) riseB++;
    if (rfBus.wr_data_valid && !prevWr) riseWr++;
    if (rfBus.wr_ack && !prevWrAck) riseWrAck++;
    prevVa    = rfBus.rd_addr_a_valid;
    prevVb    = rfBus.rd_addr_b_valid;
    prevWr    = rfBus.wr_data_valid;
    prevWrAck = rfBus.wr_ack;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every completed operand handshake.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!reset && rfBus.op_valid === 1'b1 && rfBus.op_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL opUnexpected: got a=0x%08h b=0x%08h, expected no output", rfBus.op_a, rfBus.op_b);
      end else begin
        exp = expQ.pop_front();
        checkOutput("opA", rfBus.op_a, exp[63:32]);
        checkOutput("opB", rfBus.op_b, exp[31:0]);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the request fired.
  task automatic applyStimulusRead(input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic use1, input logic use2,
                                   input logic [31:0] expA, input logic [31:0] expB);
    int n = 0;
    expQ.push_back({expA, expB});
    rfBus.req_rs1     = rs1;
    rfBus.req_rs2     = rs2;
    rfBus.req_use_rs1 = use1;
    rfBus.req_use_rs2 = use2;
    rfBus.req_valid   = 1'b1;
    @(negedge clk);
    while (!rfBus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rfBus.req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL readAccept: req_ready got 0 after %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    rfBus.req_valid = 1'b0;
  endtask

  task automatic applyStimulusWb(input logic [4:0] rd, input logic [31:0] data);
    int n = 0;
    rfBus.wb_rd    = rd;
    rfBus.wb_data  = data;
    rfBus.wb_valid = 1'b1;
    @(negedge clk);
    while (!rfBus.wb_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rfBus.wb_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL wbAccept: wb_ready got 0 after %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    rfBus.wb_valid = 1'b0;
  endtask

  task automatic waitQueueEmpty(input string name);
    int n = 0;
    @(negedge clk);
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: %0d operand results outstanding, expected 0", name, expQ.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic waitWriteIdle(input string name);
    int n = 0;
    @(negedge clk);
    while ((rfBus.wr_data_valid || rfBus.wr_ack || !rfBus.wb_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rfBus.wr_data_valid || rfBus.wr_ack || !rfBus.wb_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: write side got busy, expected idle", name);
    end
    @(posedge clk); #1;
  endtask

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0, b0, w0, ack0, n;

    reset             = 1'b1;
    blockAckA         = 1'b0;
    rfBus.req_valid   = 1'b0;
    rfBus.req_rs1     = '0;
    rfBus.req_rs2     = '0;
    rfBus.req_use_rs1 = 1'b0;
    rfBus.req_use_rs2 = 1'b0;
    rfBus.op_ready    = 1'b1;
    rfBus.wb_valid    = 1'b0;
    rfBus.wb_rd       = '0;
    rfBus.wb_data     = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkBit("rstValidA", rfBus.rd_addr_a_valid, 1'b0);
    checkBit("rstValidB", rfBus.rd_addr_b_valid, 1'b0);
    checkBit("rstWrValid", rfBus.wr_data_valid, 1'b0);
    checkBit("rstOpValid", rfBus.op_valid, 1'b0);
    checkOutput("rstOpA", rfBus.op_a, 32'h0);
    checkOutput("rstOpB", rfBus.op_b, 32'h0);
    checkBit("rstErr", errTimeout, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkBit("idleReqReady", rfBus.req_ready, 1'b1);
    checkBit("idleWbReady", rfBus.wb_ready, 1'b1);
    @(posedge clk); #1;

    // 1: write x5 then read rs1=5, rs2=0.
    $display("[TB] test 1: writeback x5 then read x5/x0");
    w0 = riseWr;
    applyStimulusWb(5'd5, 32'hDEAD_BEEF);
    waitWriteIdle("t1WriteIdle");
    checkOutput("t1WrBursts", 32'(riseWr - w0), 32'd1);
    a0 = riseA; b0 = riseB;
    applyStimulusRead(5'd5, 5'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0);
    waitQueueEmpty("t1Drain");
    checkOutput("t1PortAReads", 32'(riseA - a0), 32'd1);
    checkOutput("t1PortBReads", 32'(riseB - b0), 32'd0);

    // 2: write x7 and read rs2=7 in the same cycle.
    $display("[TB] test 2: same-cycle write/read of x7");
    ack0 = riseWrAck;
    expQ.push_back({32'h0, 32'h0000_1234});
    rfBus.wb_rd       = 5'd7;
    rfBus.wb_data     = 32'h0000_1234;
    rfBus.wb_valid    = 1'b1;
    rfBus.req_rs1     = 5'd0;
    rfBus.req_rs2     = 5'd7;
    rfBus.req_use_rs1 = 1'b0;
    rfBus.req_use_rs2 = 1'b1;
    rfBus.req_valid   = 1'b1;
    @(negedge clk);
    checkBit("t2ReqBlocked", rfBus.req_ready, 1'b0);
    checkBit("t2WbReady", rfBus.wb_ready, 1'b1);
    @(posedge clk); #1;
    rfBus.wb_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rfBus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkBit("t2ReqReleased", rfBus.req_ready, 1'b1);
    @(posedge clk); #1;
    rfBus.req_valid = 1'b0;
    checkOutput("t2AckBeforeRead", 32'(riseWrAck - ack0), 32'd1);
    waitQueueEmpty("t2Drain");

    // 3: write to x0 is dropped; reading x0 gives 0 with no bus activity.
    $display("[TB] test 3: writeback to x0");
    w0 = riseWr; a0 = riseA; b0 = riseB;
    applyStimulusWb(5'd0, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkBit("t3WrValidLow", rfBus.wr_data_valid, 1'b0);
      checkBit("t3WbReadyHigh", rfBus.wb_ready, 1'b1);
    end
    @(posedge clk); #1;
    applyStimulusRead(5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
    waitQueueEmpty("t3Drain");
    checkOutput("t3WrBursts", 32'(riseWr - w0), 32'd0);
    checkOutput("t3NoReads", 32'(riseA - a0 + riseB - b0), 32'd0);

    // 4: back-pressure on the operand output.
    $display("[TB] test 4: operand hold under op_ready=0");
    rfBus.op_ready = 1'b0;
    applyStimulusRead(5'd3, 5'd4, 1'b1, 1'b1, 32'h1000_0003, 32'h1000_0004);
    a0 = riseA; b0 = riseB;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rfBus.op_valid && n < 50);
    checkOutput("t4Latency", 32'(n), 32'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkBit("t4OpValidHeld", rfBus.op_valid, 1'b1);
      checkOutput("t4OpAStable", rfBus.op_a, 32'h1000_0003);
      checkOutput("t4OpBStable", rfBus.op_b, 32'h1000_0004);
      checkBit("t4ReqReadyLow", rfBus.req_ready, 1'b0);
    end
    @(posedge clk); #1;
    checkOutput("t4PortAReads", 32'(riseA - a0), 32'd1);
    checkOutput("t4PortBReads", 32'(riseB - b0), 32'd1);
    rfBus.op_ready = 1'b1;
    waitQueueEmpty("t4Drain");

    // 5: reset while reads are in flight.
    $display("[TB] test 5: reset during read issue");
    applyStimulusRead(5'd3, 5'd6, 1'b1, 1'b1, 32'h1000_0003, 32'h1000_0006);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkBit("t5ValidAClear", rfBus.rd_addr_a_valid, 1'b0);
    checkBit("t5ValidBClear", rfBus.rd_addr_b_valid, 1'b0);
    checkBit("t5OpValidClear", rfBus.op_valid, 1'b0);
    expQ.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    applyStimulusRead(5'd3, 5'd6, 1'b1, 1'b1, 32'h1000_0003, 32'h1000_0006);
    waitQueueEmpty("t5Drain");

    // 7: non-overlapping read and write proceed together.
    $display("[TB] test 7: concurrent independent read and write");
    expQ.push_back({32'h1000_0003, 32'h1000_0004});
    rfBus.wb_rd       = 5'd10;
    rfBus.wb_data     = 32'h0000_AAAA;
    rfBus.wb_valid    = 1'b1;
    rfBus.req_rs1     = 5'd3;
    rfBus.req_rs2     = 5'd4;
    rfBus.req_use_rs1 = 1'b1;
    rfBus.req_use_rs2 = 1'b1;
    rfBus.req_valid   = 1'b1;
    @(negedge clk);
    checkBit("t7ReqReady", rfBus.req_ready, 1'b1);
    @(posedge clk); #1;
    rfBus.wb_valid  = 1'b0;
    rfBus.req_valid = 1'b0;
    waitQueueEmpty("t7Drain");
    waitWriteIdle("t7WriteIdle");
    applyStimulusRead(5'd10, 5'd0, 1'b1, 1'b0, 32'h0000_AAAA, 32'h0);
    waitQueueEmpty("t7Readback");

`ifdef REGFILE_CTRL_TIMEOUT_EN
    // 6: port a never acks; watchdog aborts the read.
    $display("[TB] test 6: read ack watchdog");
    blockAckA = 1'b1;
    applyStimulusRead(5'd9, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (!errTimeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkBit("t6ErrTimeout", errTimeout, 1'b1);
    waitQueueEmpty("t6Drain");
    blockAckA = 1'b0;
    applyStimulusRead(5'd9, 5'd0, 1'b1, 1'b0, 32'h1000_0009, 32'h0);
    waitQueueEmpty("t6Recover");
    checkBit("t6ErrSticky", errTimeout, 1'b1);
`else
    checkBit("errTimeoutTied", errTimeout, 1'b0);
`endif

    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
